level_sequencer: RTL and testbench
==================================

LEVEL_SEQUENCER -- requirements
Module: level_sequencer

Interface
REQ-001 Parameters (name, default, meaning):
- NUM_LEVELS, 16: levels per game.
- LEVEL_W, 5: width of level.
- DIFF_W, 7: width of symCountDiff.
- PRELIM_SECS, 3: countdown length.
- SHOW_SECS, 20: symbol display length.
- ANSWER_SECS, 3: answer window length.
- POST_SECS, 5: post-level length.
- TOL_BASE, 3: level-0 pass tolerance.
- TOL_MIN, 1: tolerance floor.
- TOL_STEP, 4: levels per tolerance decrement.
- LIVES, 3: failures allowed before loss.
- All *_SECS values are at least 1.
REQ-002 Ports (name, direction, width, meaning):
- Clk1hz, in, 1: game tick; the block is clocked on its rising edge.
- reset, in, 1: asynchronous, active-high.
- start, in, 1: begins a game; sampled only in IDLE or OVER.
- symCountDiff, in, DIFF_W: absolute player count error, unsigned.
- level, out, LEVEL_W: current level, 0-based.
- levelChng, out, 1: one-cycle pulse on level advance.
- prelimPeriod, out, 1: asserted in PRELIM.
- showPeriod, out, 1: asserted in SHOW.
- answerPeriod, out, 1: asserted in ANSWER.
- postPeriod, out, 1: asserted in POST.
- countDownTime, out, 3: seconds remaining in PRELIM; 0 otherwise.
- livesLeft, out, 3: remaining lives.
- loss, out, 1: sticky game-lost flag.
- win, out, 1: sticky game-won flag.

Function
REQ-003 The FSM SHALL have the states IDLE, PRELIM, SHOW, ANSWER, POST and OVER, with exactly one state register updated on Clk1hz.
REQ-004 The phase timer SHALL load (duration-1) on phase entry and decrement once per tick; at timer==0 the FSM SHALL move to the next phase, so each phase lasts exactly its *_SECS ticks.
REQ-005 Transitions:
- IDLE to PRELIM on start=1.
- PRELIM to SHOW, SHOW to ANSWER, ANSWER to POST on timer expiry.
- POST expiry SHALL trigger judgement (REQ-007).
REQ-006 Period outputs SHALL be registered and one-hot with the state; all period outputs SHALL be 0 in IDLE and OVER.
REQ-007 Judgement SHALL sample symCountDiff only on the final POST tick:
- Pass condition: symCountDiff < tol(level).
- Pass with level < NUM_LEVELS-1: level+1, levelChng=1 for one tick, go to PRELIM.
- Pass with level == NUM_LEVELS-1: win=1, go to OVER, level unchanged.
- Fail with livesLeft > 1: livesLeft-1, level unchanged, go to PRELIM to retry; levelChng stays 0.
- Fail with livesLeft == 1: livesLeft=0, loss=1, go to OVER.
REQ-008 tol(level) SHALL equal max(TOL_MIN, TOL_BASE - level/TOL_STEP), using integer division and saturating so it never underflows below TOL_MIN.
REQ-009 In PRELIM, countDownTime SHALL equal timer+1, reading PRELIM_SECS down to 1; it SHALL read 0 in every other state.
REQ-010 In OVER, the block SHALL hold level, loss and win; start=1 SHALL clear loss and win, set level=0 and livesLeft=LIVES, and go to PRELIM.
REQ-011 start SHALL be ignored in PRELIM, SHOW, ANSWER and POST.
REQ-012 symCountDiff SHALL be ignored outside the judgement tick.
REQ-013 loss and win SHALL never both be 1.
REQ-014 levelChng SHALL never assert on a retry or on the final-level win.

Reset
REQ-015 reset=1 SHALL immediately, without waiting for a clock edge, force:
- state=IDLE, timer=0, level=0, livesLeft=LIVES.
- All period outputs, countDownTime, levelChng, loss and win to 0.
REQ-016 Reset asserted mid-phase SHALL abandon the game; no judgement SHALL occur.
REQ-017 After reset is released, the first start SHALL begin a fresh game.

Structure
REQ-018 The package level_seq_pkg SHALL hold:
- the state enum;
- default parameter constants;
- the tolerance function.
REQ-019 The sub-module phase_timer SHALL be a loadable down-counter with a done flag, parametrised by width; level_sequencer SHALL instantiate it once.

Verification
REQ-020 Defaults, start pulse in IDLE -> prelimPeriod for 3 ticks with countDownTime reading 3,2,1; showPeriod for 20 ticks; answerPeriod for 3 ticks; postPeriod for 5 ticks.
REQ-021 symCountDiff=2 at level 0 judgement -> levelChng pulses for 1 tick, level=1, prelimPeriod asserts.
REQ-022 symCountDiff=5 on three consecutive judgements of level 0 -> livesLeft goes 2, then 1, then 0; loss=1 and state=OVER; level stays 0.
REQ-023 At level 8, tol=1: symCountDiff=1 -> fail; symCountDiff=0 -> pass.
REQ-024 Passing level 15 -> win=1, levelChng=0, level=15; then start -> level=0, win=0, livesLeft=3.
REQ-025 reset asserted mid-SHOW at level 4 -> all outputs reach reset values before the next edge; start toggling during SHOW before the reset has no effect.

Source files
------------

// File: rtl/level_seq_pkg.sv
// Shared types, default game constants and the level-dependent pass tolerance
// for the level sequencer.
package level_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRELIM,
    SHOW,
    ANSWER,
    POST,
    OVER
  } state_e;

  localparam int NUM_LEVELS_DEF  = 16;
  localparam int LEVEL_W_DEF     = 5;
  localparam int DIFF_W_DEF      = 7;
  localparam int PRELIM_SECS_DEF = 3;
  localparam int SHOW_SECS_DEF   = 20;
  localparam int ANSWER_SECS_DEF = 3;
  localparam int POST_SECS_DEF   = 5;
  localparam int TOL_BASE_DEF    = 3;
  localparam int TOL_MIN_DEF     = 1;
  localparam int TOL_STEP_DEF    = 4;
  localparam int LIVES_DEF       = 3;

  // Tolerance shrinks by one every `step` levels and never drops below `floor_v`.
  function automatic int tol_f(input int lvl, input int base, input int floor_v, input int step);
    int reduced;
    reduced = base - (lvl / step);
    return (reduced < floor_v) ? floor_v : reduced;
  endfunction

endpackage

// File: rtl/level_sequencer_if.sv
// Game-control bundle between the sequencer (slave) and the game logic (master).
interface level_sequencer_if #(
  parameter int LEVEL_W = 5,
  parameter int DIFF_W  = 7
);
  logic               start;
  logic [DIFF_W-1:0]  symCountDiff;
  logic [LEVEL_W-1:0] level;
  logic               levelChng;
  logic               prelimPeriod;
  logic               showPeriod;
  logic               answerPeriod;
  logic               postPeriod;
  logic [2:0]         countDownTime;
  logic [2:0]         livesLeft;
  logic               loss;
  logic               win;

  modport master (
    output start, symCountDiff,
    input  level, levelChng, prelimPeriod, showPeriod, answerPeriod, postPeriod,
    input  countDownTime, livesLeft, loss, win
  );

  modport slave (
    input  start, symCountDiff,
    output level, levelChng, prelimPeriod, showPeriod, answerPeriod, postPeriod,
    output countDownTime, livesLeft, loss, win
  );
endinterface

// File: rtl/level_sequencer_timer.sv
// Loadable down-counter that stops at zero; done_o flags the last tick of a phase.
module phase_timer #(
  parameter int W = 5
) (
  input  logic         Clk1hz,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic [W-1:0] count_o,
  output logic         done_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge Clk1hz or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_q <= count_q - W'(1);
    end
  end

  assign count_o = count_q;
  assign done_o  = (count_q == '0);

endmodule

// File: rtl/level_sequencer.sv
// Game phase sequencer: countdown, show, answer and post phases per level, with
// judgement of the player's count error at the end of each level.
module level_sequencer
  import level_seq_pkg::*;
#(
  parameter int NUM_LEVELS  = NUM_LEVELS_DEF,
  parameter int LEVEL_W     = LEVEL_W_DEF,
  parameter int DIFF_W      = DIFF_W_DEF,
  parameter int PRELIM_SECS = PRELIM_SECS_DEF,
  parameter int SHOW_SECS   = SHOW_SECS_DEF,
  parameter int ANSWER_SECS = ANSWER_SECS_DEF,
  parameter int POST_SECS   = POST_SECS_DEF,
  parameter int TOL_BASE    = TOL_BASE_DEF,
  parameter int TOL_MIN     = TOL_MIN_DEF,
  parameter int TOL_STEP    = TOL_STEP_DEF,
  parameter int LIVES       = LIVES_DEF
) (
  input logic                Clk1hz,
  input logic                reset,
  level_sequencer_if.slave   bus
);

  localparam int MAX_AB   = (PRELIM_SECS > SHOW_SECS) ? PRELIM_SECS : SHOW_SECS;
  localparam int MAX_CD   = (ANSWER_SECS > POST_SECS) ? ANSWER_SECS : POST_SECS;
  localparam int MAX_SECS = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int TW       = $clog2(MAX_SECS + 1);

  state_e             state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [2:0]         lives_q, lives_d;
  logic               loss_q, loss_d;
  logic               win_q, win_d;
  logic               chng_q, chng_d;
  logic               prelim_q, show_q, answer_q, post_q;

  logic               tmr_load;
  logic [TW-1:0]      tmr_val;
  logic               tmr_en;
  logic [TW-1:0]      tmr_count;
  logic               tmr_done;
  logic               pass;

  phase_timer #(.W(TW)) u_timer (
    .Clk1hz     (Clk1hz),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .en_i       (tmr_en),
    .count_o    (tmr_count),
    .done_o     (tmr_done)
  );

  assign pass = int'(bus.symCountDiff) <
                tol_f(int'(level_q), TOL_BASE, TOL_MIN, TOL_STEP);

  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    lives_d  = lives_q;
    loss_d   = loss_q;
    win_d    = win_q;
    chng_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_en   = 1'b0;

    case (state_q)
      IDLE, OVER: begin
        if (bus.start) begin
          state_d  = PRELIM;
          level_d  = '0;
          lives_d  = 3'(LIVES);
          loss_d   = 1'b0;
          win_d    = 1'b0;
          tmr_load = 1'b1;
          tmr_val  = TW'(PRELIM_SECS - 1);
        end
      end
      PRELIM: begin
        tmr_en = 1'b1;
        if (tmr_done) begin
          state_d  = SHOW;
          tmr_load = 1'b1;
          tmr_val  = TW'(SHOW_SECS - 1);
        end
      end
      SHOW: begin
        tmr_en = 1'b1;
        if (tmr_done) begin
          state_d  = ANSWER;
          tmr_load = 1'b1;
          tmr_val  = TW'(ANSWER_SECS - 1);
        end
      end
      ANSWER: begin
        tmr_en = 1'b1;
        if (tmr_done) begin
          state_d  = POST;
          tmr_load = 1'b1;
          tmr_val  = TW'(POST_SECS - 1);
        end
      end
      POST: begin
        tmr_en = 1'b1;
        // Final POST tick: the only moment the player's error is looked at.
        if (tmr_done) begin
          if (pass && (level_q == LEVEL_W'(NUM_LEVELS - 1))) begin
            state_d = OVER;
            win_d   = 1'b1;
          end else if (pass) begin
            state_d  = PRELIM;
            level_d  = level_q + LEVEL_W'(1);
            chng_d   = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = TW'(PRELIM_SECS - 1);
          end else if (lives_q > 3'd1) begin
            state_d  = PRELIM;
            lives_d  = lives_q - 3'd1;
            tmr_load = 1'b1;
            tmr_val  = TW'(PRELIM_SECS - 1);
          end else begin
            state_d = OVER;
            lives_d = 3'd0;
            loss_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Period flags are registered from the next state so they stay one-hot with state_q.
  always_ff @(posedge Clk1hz or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      level_q  <= '0;
      lives_q  <= 3'(LIVES);
      loss_q   <= 1'b0;
      win_q    <= 1'b0;
      chng_q   <= 1'b0;
      prelim_q <= 1'b0;
      show_q   <= 1'b0;
      answer_q <= 1'b0;
      post_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      lives_q  <= lives_d;
      loss_q   <= loss_d;
      win_q    <= win_d;
      chng_q   <= chng_d;
      prelim_q <= (state_d == PRELIM);
      show_q   <= (state_d == SHOW);
      answer_q <= (state_d == ANSWER);
      post_q   <= (state_d == POST);
    end
  end

  assign bus.level         = level_q;
  assign bus.levelChng     = chng_q;
  assign bus.prelimPeriod  = prelim_q;
  assign bus.showPeriod    = show_q;
  assign bus.answerPeriod  = answer_q;
  assign bus.postPeriod    = post_q;
  assign bus.countDownTime = (state_q == PRELIM) ? (3'(tmr_count) + 3'd1) : 3'd0;
  assign bus.livesLeft     = lives_q;
  assign bus.loss          = loss_q;
  assign bus.win           = win_q;

endmodule

// File: tb/tb_level_sequencer.sv
// Directed bench for level_sequencer with default parameters; outputs sampled on the falling edge.
module tb_level_sequencer;

  logic Clk1hz = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  level_sequencer_if #(.LEVEL_W(5), .DIFF_W(7)) bus ();

  level_sequencer dut (
    .Clk1hz (Clk1hz),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 Clk1hz = ~Clk1hz;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s: %0d @%0t", tag, got, $time);
    end
  endtask

  task automatic begin_game();
    bus.start = 1'b1;
    @(negedge Clk1hz);
    bus.start = 1'b0;
  endtask

  // Entered at the falling edge right after PRELIM was entered; returns after judgement.
  task automatic play(input int diff);
    for (int i = 0; i < 3; i++) begin
      if (bus.prelimPeriod !== 1'b1) chk("prelim", bus.prelimPeriod, 1);
      chk("cdt", bus.countDownTime, 3 - i);
      if (i == 1) chk("chng_one_tick", bus.levelChng, 0);
      @(negedge Clk1hz);
    end
    for (int i = 0; i < 20; i++) begin
      if (i == 0) begin
        chk("show_first", bus.showPeriod, 1);
        chk("cdt_zero_show", bus.countDownTime, 0);
        chk("prelim_off", bus.prelimPeriod, 0);
      end else if (bus.showPeriod !== 1'b1) chk("show", bus.showPeriod, 1);
      @(negedge Clk1hz);
    end
    for (int i = 0; i < 3; i++) begin
      if (bus.answerPeriod !== 1'b1 || i == 0) chk("answer", bus.answerPeriod, 1);
      @(negedge Clk1hz);
    end
    for (int i = 0; i < 5; i++) begin
      if (bus.postPeriod !== 1'b1 || i == 0) chk("post", bus.postPeriod, 1);
      if (i == 4) bus.symCountDiff = 7'(diff);
      @(negedge Clk1hz);
    end
    bus.symCountDiff = 7'd127;
    $display("level judged with diff=%0d -> level=%0d lives=%0d", diff, bus.level, bus.livesLeft);
  endtask

  initial begin
    reset            = 1'b1;
    bus.start        = 1'b0;
    bus.symCountDiff = 7'd127;
    #2;
    chk("rst_level", bus.level, 0);
    chk("rst_lives", bus.livesLeft, 3);
    chk("rst_prelim", bus.prelimPeriod, 0);
    chk("rst_cdt", bus.countDownTime, 0);
    @(negedge Clk1hz);
    reset = 1'b0;
    @(negedge Clk1hz);
    chk("idle_prelim", bus.prelimPeriod, 0);

    // Level 0 pass with diff=2 (tol 3); junk diff outside the judgement tick.
    begin_game();
    play(2);
    chk("adv_chng", bus.levelChng, 1);
    chk("adv_level", bus.level, 1);
    chk("adv_prelim", bus.prelimPeriod, 1);
    chk("adv_lives", bus.livesLeft, 3);
    for (int l = 1; l < 8; l++) play(0);
    chk("lvl8", bus.level, 8);

    // Level 8: tol=1, diff=1 fails, diff=0 passes.
    play(1);
    chk("l8_fail_lives", bus.livesLeft, 2);
    chk("l8_fail_level", bus.level, 8);
    chk("l8_fail_chng", bus.levelChng, 0);
    chk("l8_retry_prelim", bus.prelimPeriod, 1);
    play(0);
    chk("l8_pass_level", bus.level, 9);
    for (int l = 9; l < 15; l++) play(0);
    chk("lvl15", bus.level, 15);

    // Final level win.
    play(0);
    chk("win", bus.win, 1);
    chk("win_loss", bus.loss, 0);
    chk("win_chng", bus.levelChng, 0);
    chk("win_level", bus.level, 15);
    chk("win_prelim", bus.prelimPeriod, 0);
    @(negedge Clk1hz);
    chk("win_hold", bus.win, 1);
    begin_game();
    chk("restart_level", bus.level, 0);
    chk("restart_win", bus.win, 0);
    chk("restart_lives", bus.livesLeft, 3);
    chk("restart_prelim", bus.prelimPeriod, 1);

    // Three failures at level 0.
    play(5);
    chk("loss_l2", bus.livesLeft, 2);
    play(5);
    chk("loss_l1", bus.livesLeft, 1);
    play(5);
    chk("loss_l0", bus.livesLeft, 0);
    chk("loss_flag", bus.loss, 1);
    chk("loss_win", bus.win, 0);
    chk("loss_level", bus.level, 0);
    chk("loss_prelim", bus.prelimPeriod, 0);
    @(negedge Clk1hz);
    chk("loss_hold", bus.loss, 1);
    chk("over_post", bus.postPeriod, 0);

    // New game, lose one life, reach level 4, then reset mid-SHOW.
    begin_game();
    chk("new_loss", bus.loss, 0);
    play(5);
    for (int l = 0; l < 4; l++) play(0);
    chk("lvl4", bus.level, 4);
    chk("lvl4_lives", bus.livesLeft, 2);
    for (int i = 0; i < 3; i++) @(negedge Clk1hz);
    bus.start = 1'b1;
    @(negedge Clk1hz);
    bus.start = 1'b0;
    @(negedge Clk1hz);
    chk("show_start_ign", bus.showPeriod, 1);
    chk("show_start_lvl", bus.level, 4);
    chk("show_start_prelim", bus.prelimPeriod, 0);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_level", bus.level, 0);
    chk("mid_rst_lives", bus.livesLeft, 3);
    chk("mid_rst_show", bus.showPeriod, 0);
    chk("mid_rst_cdt", bus.countDownTime, 0);
    chk("mid_rst_chng", bus.levelChng, 0);
    chk("mid_rst_lw", {30'd0, bus.loss, bus.win}, 0);
    @(negedge Clk1hz);
    reset = 1'b0;
    @(negedge Clk1hz);
    @(negedge Clk1hz);
    chk("post_rst_idle", {bus.prelimPeriod, bus.showPeriod, bus.answerPeriod, bus.postPeriod}, 0);
    begin_game();
    chk("fresh_prelim", bus.prelimPeriod, 1);
    chk("fresh_cdt", bus.countDownTime, 3);
    chk("fresh_level", bus.level, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
